sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Purpose:
//    Shares one SDRAM controller port between a single write requester (ROM
//    download) and NUM_PORTS read requesters. One transaction is outstanding at
//    a time. Writes always win over reads. Read-port selection is either fixed
//    priority (lowest index wins, default build) or round-robin when the macro
//    SDRAM_ARBITER_ROUND_ROBIN_EN is defined.
//
// Parameters:
//    NUM_PORTS  - number of read requesters (2..8)
//    ADDR_WIDTH - SDRAM word address width
//    DATA_WIDTH - SDRAM data width
//
// Ports:
//    clk, reset                     - clock, synchronous active-high reset
//    wr_req/wr_addr/wr_data         - write requester (level request)
//    wr_ack                         - write accepted (combinational pulse)
//    port_req/port_addr             - per-port read requests, packed addresses
//    port_ack                       - read accepted (combinational pulse)
//    port_valid/port_q              - registered read-data pulse and shared data
//    sdram_addr/data/we/req         - registered command to SDRAM controller
//    sdram_ack/valid/q              - responses from SDRAM controller
//
// Configuration macro: SDRAM_ARBITER_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
module sdram_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_req,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   output logic                            wr_ack,
   input  logic [NUM_PORTS-1:0]            port_req,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
   output logic [NUM_PORTS-1:0]            port_ack,
   output logic [NUM_PORTS-1:0]            port_valid,
   output logic [DATA_WIDTH-1:0]           port_q,
   output logic [ADDR_WIDTH-1:0]           sdram_addr,
   output logic [DATA_WIDTH-1:0]           sdram_data,
   output logic                            sdram_we,
   output logic                            sdram_req,
   input  logic                            sdram_ack,
   input  logic                            sdram_valid,
   input  logic [DATA_WIDTH-1:0]           sdram_q
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_VALID} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   we_q, we_d;
   logic                   sdram_req_q, sdram_req_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [NUM_PORTS-1:0]   port_valid_q, port_valid_d;
   logic [DATA_WIDTH-1:0]  port_q_q, port_q_d;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
   // Holds the index where the next search begins (last read grant + 1).
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
`endif

   logic [ADDR_WIDTH-1:0]  port_addr_arr [NUM_PORTS];
   logic [IDX_W-1:0]       sel_idx;
   logic                   sel_found;
   logic                   ack_fire;

   // Unpack the flat address bus into one word per port.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_addr
         assign port_addr_arr[gi] = port_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      end
   endgenerate

   // Acks are combinational on sdram_ack; reset masks them so an abandoned
   // transaction never produces a pulse.
   assign ack_fire = (state_q == WAIT_ACK) && sdram_ack && !reset;
   assign wr_ack   = ack_fire && we_q;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
         assign port_ack[gi] = ack_fire && !we_q && (grant_q == IDX_W'(gi));
      end
   endgenerate

   // Read-port selection.
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
   always_comb begin
      int cand;
      cand      = 0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
         if (!sel_found && port_req[cand[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end
`else
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!sel_found && port_req[IDX_W'(k)]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(k);
         end
      end
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = we_q;
      sdram_req_d  = sdram_req_q;
      grant_d      = grant_q;
      port_valid_d = '0;
      port_q_d     = port_q_q;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      rr_ptr_d     = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               addr_d      = wr_addr;
               data_d      = wr_data;
               we_d        = 1'b1;
               sdram_req_d = 1'b1;
               state_d     = WAIT_ACK;
            end else if (sel_found) begin
               addr_d      = port_addr_arr[sel_idx];
               we_d        = 1'b0;
               grant_d     = sel_idx;
               sdram_req_d = 1'b1;
               state_d     = WAIT_ACK;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
               rr_ptr_d    = (sel_idx == IDX_W'(NUM_PORTS-1)) ? '0 : sel_idx + IDX_W'(1);
`endif
            end
         end
         WAIT_ACK: begin
            if (sdram_ack) begin
               sdram_req_d = 1'b0;
               state_d     = we_q ? IDLE : WAIT_VALID;
            end
         end
         WAIT_VALID: begin
            if (sdram_valid) begin
               port_q_d              = sdram_q;
               port_valid_d[grant_q] = 1'b1;
               state_d               = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            sdram_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         sdram_req_q  <= 1'b0;
         grant_q      <= '0;
         port_valid_q <= '0;
         port_q_q     <= '0;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         sdram_req_q  <= sdram_req_d;
         grant_q      <= grant_d;
         port_valid_q <= port_valid_d;
         port_q_q     <= port_q_d;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
         rr_ptr_q     <= rr_ptr_d;
`endif
      end
   end

   assign sdram_req  = sdram_req_q;
   assign sdram_addr = addr_q;
   assign sdram_data = data_q;
   assign sdram_we   = we_q;
   assign port_valid = port_valid_q;
   assign port_q     = port_q_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Purpose:
//    Self-checking bench for sdram_arbiter: a table of transactions driven
//    through a small SDRAM responder with a scoreboard queue, plus hand-written
//    sequences for round-robin order, reset mid-transaction and spurious
//    controller responses. Honors SDRAM_ARBITER_ROUND_ROBIN_EN for expected
//    grant order.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

   localparam int NP = 4;
   localparam int AW = 23;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_req = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [DW-1:0]     wr_data = '0;
   logic              wr_ack;
   logic [NP-1:0]     port_req = '0;
   logic [NP*AW-1:0]  port_addr = '0;
   logic [NP-1:0]     port_ack;
   logic [NP-1:0]     port_valid;
   logic [DW-1:0]     port_q;
   logic [AW-1:0]     sdram_addr;
   logic [DW-1:0]     sdram_data;
   logic              sdram_we;
   logic              sdram_req;
   logic              sdram_ack = 1'b0;
   logic              sdram_valid = 1'b0;
   logic [DW-1:0]     sdram_q = '0;

   sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .port_req(port_req), .port_addr(port_addr), .port_ack(port_ack),
      .port_valid(port_valid), .port_q(port_q),
      .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
      .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
      .sdram_q(sdram_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [NP-1:0] preq;
      logic [AW-1:0] base;
      logic [DW-1:0] wdata;
      int            ack_dly;
      int            val_dly;
      logic [DW-1:0] rdata;
      logic          drop;
   } vec_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [NP:0]   ackvec;   // {port_ack, wr_ack}
      logic [NP-1:0] valid;
      logic [DW-1:0] q;
      int            port;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   errors = 0;
   int   checks = 0;
   int   model_ptr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Reference arbitration: lowest index, or round-robin from model_ptr.
   function automatic int model_pick(input logic [NP-1:0] req);
      int c;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      for (int k = 0; k < NP; k++) begin
         c = (model_ptr + k) % NP;
         if (req[c]) return c;
      end
`else
      for (int k = 0; k < NP; k++) begin
         c = k;
         if (req[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic set_addrs(input logic [AW-1:0] base);
      for (int i = 0; i < NP; i++) port_addr[i*AW +: AW] = base + AW'(i * 256);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_req = 1'b0; port_req = '0; sdram_ack = 1'b0; sdram_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      model_ptr = 0;
   endtask

   task automatic run_txn(input vec_t v);
      exp_t e;
      exp_t got;
      int   n;
      int   p;
      wr_req = v.wr; wr_addr = v.base; wr_data = v.wdata; port_req = v.preq;
      set_addrs(v.base);
      e.data = v.wdata; e.q = v.rdata; e.port = -1;
      if (v.wr) begin
         e.we = 1'b1; e.addr = v.base; e.ackvec = 1; e.valid = '0;
      end else begin
         p = model_pick(v.preq);
         e.port = p; e.we = 1'b0;
         e.addr = v.base + AW'(p * 256);
         e.ackvec = (NP+1)'(1) << (p + 1);
         e.valid = NP'(1) << p;
         model_ptr = (p + 1) % NP;
      end
      sb.push_back(e);
      n = 0;
      do begin step(); n++; end while (!sdram_req && n < 8);
      got = sb.pop_front();
      if (!sdram_req) begin
         chk("req_timeout", 64'(sdram_req), 64'(1));
         wr_req = 1'b0; port_req = '0;
         return;
      end
      chk("req_latency", 64'(n), 64'(1));
      chk("sdram_we", 64'(sdram_we), 64'(got.we));
      chk("sdram_addr", 64'(sdram_addr), 64'(got.addr));
      if (got.we) chk("sdram_data", 64'(sdram_data), 64'(got.data));
      if (v.drop) port_req = '0;
      for (int c = 0; c < v.ack_dly; c++) begin
         step();
         chk("req_held", 64'(sdram_req), 64'(1));
         chk("addr_held", 64'(sdram_addr), 64'(got.addr));
         chk("early_ack", 64'({port_ack, wr_ack}), 64'(0));
      end
      sdram_ack = 1'b1;
      #1;
      chk("ack_vec", 64'({port_ack, wr_ack}), 64'(got.ackvec));
      step();
      sdram_ack = 1'b0; wr_req = 1'b0; port_req = '0;
      #1;
      chk("req_low_after_ack", 64'(sdram_req), 64'(0));
      if (got.we) begin
         $display("txn write addr=%0h data=%0h acked", got.addr, got.data);
         return;
      end
      for (int c = 1; c < v.val_dly; c++) begin
         step();
         chk("no_early_valid", 64'(port_valid), 64'(0));
      end
      sdram_valid = 1'b1; sdram_q = v.rdata;
      step();
      sdram_valid = 1'b0; sdram_q = 32'h5A5A_5A5A;
      chk("port_valid", 64'(port_valid), 64'(got.valid));
      chk("port_q", 64'(port_q), 64'(got.q));
      step();
      chk("valid_pulse_end", 64'(port_valid), 64'(0));
      chk("port_q_hold", 64'(port_q), 64'(got.q));
      $display("txn read port=%0d addr=%0h q=%0h", got.port, got.addr, port_q);
   endtask

   initial begin : main
      int exp_order[5];
      int idx;
      `ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      exp_order = '{0, 1, 2, 3, 0};
      `else
      exp_order = '{0, 0, 0, 0, 0};
      `endif

      //            wr    preq     base         wdata         ack val rdata         drop
      vecs[0] = '{1'b0, 4'b0010, 23'h000000, 32'h0,        2, 3, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b1, 4'b1111, 23'h000010, 32'h12345678, 1, 1, 32'h0,        1'b0};
      vecs[2] = '{1'b0, 4'b1111, 23'h002000, 32'h0,        0, 1, 32'hA5A50001, 1'b0};
      vecs[3] = '{1'b0, 4'b1001, 23'h003000, 32'h0,        3, 2, 32'h0BADF00D, 1'b0};
      vecs[4] = '{1'b0, 4'b0100, 23'h004000, 32'h0,        1, 1, 32'h13572468, 1'b1};
      vecs[5] = '{1'b0, 4'b1010, 23'h7FF000, 32'h0,        0, 1, 32'hFFFFFFFF, 1'b0};
      vecs[6] = '{1'b1, 4'b0000, 23'h7FFFFF, 32'hFFFFFFFF, 0, 1, 32'h0,        1'b0};
      vecs[7] = '{1'b0, 4'b1000, 23'h001000, 32'h0,        2, 2, 32'h00000000, 1'b0};

      // Reset state
      step();
      chk("rst_sdram_req", 64'(sdram_req), 64'(0));
      chk("rst_sdram_we", 64'(sdram_we), 64'(0));
      chk("rst_sdram_addr", 64'(sdram_addr), 64'(0));
      chk("rst_sdram_data", 64'(sdram_data), 64'(0));
      chk("rst_acks", 64'({port_ack, wr_ack}), 64'(0));
      chk("rst_port_valid", 64'(port_valid), 64'(0));
      chk("rst_port_q", 64'(port_q), 64'(0));
      do_reset();

      // Table-driven transactions
      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // Held requests on all ports with immediate ack/valid: grant order
      do_reset();
      set_addrs(23'h010000);
      port_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         int n;
         n = 0;
         do begin step(); n++; end while (!sdram_req && n < 8);
         if (!sdram_req) begin
            chk("rr_req_timeout", 64'(sdram_req), 64'(1));
            break;
         end
         sdram_ack = 1'b1;
         #1;
         idx = -1;
         for (int b = 0; b < NP; b++) if (port_ack[b]) idx = b;
         chk("rr_grant", 64'(idx), 64'(exp_order[g]));
         step();
         sdram_ack = 1'b0; sdram_valid = 1'b1; sdram_q = DW'(g + 100);
         step();
         sdram_valid = 1'b0;
         chk("rr_valid", 64'(port_valid), 64'(NP'(1) << exp_order[g]));
         $display("txn held-req grant %0d -> port %0d", g, idx);
      end
      port_req = '0;
      step();

      // Reset while waiting for read data on port 3
      set_addrs(23'h020000);
      port_req = 4'b1000;
      begin
         int n;
         n = 0;
         do begin step(); n++; end while (!sdram_req && n < 8);
         chk("p3_req_seen", 64'(sdram_req), 64'(1));
      end
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0; port_req = '0; reset = 1'b1;
      step();
      reset = 1'b0; sdram_valid = 1'b1; sdram_q = 32'h55AA55AA;
      #1;
      chk("rst_mid_no_ack", 64'({port_ack, wr_ack}), 64'(0));
      step();
      sdram_valid = 1'b0;
      chk("rst_mid_no_valid", 64'(port_valid), 64'(0));
      chk("rst_mid_req", 64'(sdram_req), 64'(0));
      chk("rst_mid_port_q", 64'(port_q), 64'(0));
      step();
      chk("rst_mid_no_valid2", 64'(port_valid), 64'(0));
      $display("txn reset during WAIT_VALID checked");
      model_ptr = 0;

      // Spurious responses while idle
      run_txn('{1'b0, 4'b0001, 23'h030000, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0});
      sdram_valid = 1'b1; sdram_ack = 1'b1; sdram_q = 32'hBAD0BAD0;
      #1;
      chk("spur_ack", 64'({port_ack, wr_ack}), 64'(0));
      step();
      sdram_valid = 1'b0; sdram_ack = 1'b0;
      chk("spur_valid", 64'(port_valid), 64'(0));
      chk("spur_port_q", 64'(port_q), 64'(32'hCAFEF00D));
      chk("spur_req", 64'(sdram_req), 64'(0));
      $display("txn spurious idle response checked");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
